miriscv_store_unit: RTL and testbench
=====================================

# miriscv_store_unit

Store-side companion to the core's load sign-extension path. It accepts one store request at a time from the execute stage and converts the store size and address into a word-aligned bus address, byte-lane-replicated write data and byte enables. It runs the request/grant/response handshake on the data memory port and reports completion, misalignment or bus timeout back to the pipeline.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 0: maximum cycles spent in REQ or RSP before abort. 0 disables the timeout.
- `CNT_WIDTH`, default 8: width of the timeout counter. Requirement: `TIMEOUT_CYCLES < 2**CNT_WIDTH`.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  1  store request from the core; sampled only while `busy_o`=0.
- `size_i`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy_o`  out  1  transaction in progress.
- `done_o`  out  1  one-cycle pulse: store completed.
- `misalign_o`  out  1  one-cycle pulse: request rejected (misaligned address or reserved size).
- `timeout_o`  out  1  one-cycle pulse: transaction aborted by timeout.
- `data_req_o`  out  1  memory request.
- `data_we_o`  out  1  write enable; always 1 while `data_req_o`=1, 0 otherwise.
- `data_be_o`  out  4  byte enables.
- `data_addr_o`  out  32  word address; bits [1:0] are always 00.
- `data_wdata_o`  out  32  lane-replicated write data.
- `data_gnt_i`  in  1  grant for the current request.
- `data_rvalid_i`  in  1  write response.

## Operation
- FSM states: IDLE, REQ, RSP. `busy_o` = (state != IDLE).
- IDLE with `req_i`=1:
  - Misaligned or reserved request: halfword with `addr[0]`=1, word with `addr[1:0]`≠00, or `size_i`=11. The unit stays in IDLE and pulses `misalign_o` in the next cycle. No bus request is issued.
  - Otherwise the unit registers address, byte enables and data, and enters REQ.
- Byte-lane formatting is registered on acceptance:
  - Byte: data = {4{wdata[7:0]}}, be = 0001 << `addr[1:0]`.
  - Halfword: data = {2{wdata[15:0]}}, be = 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - Word: data = `wdata_i`, be = 1111.
  - `data_addr_o` = {`addr[31:2]`, 00}.
- REQ: `data_req_o`=1. Address, be and data are held stable until grant. `data_gnt_i`=1 moves to RSP. `data_rvalid_i` is ignored in REQ.
- RSP: `data_req_o`=0. `data_rvalid_i`=1 returns to IDLE and pulses `done_o` in the next cycle. `data_gnt_i` is ignored in RSP.
- `req_i` is ignored while busy. There is no queue; the core must hold or retry the request.
- Timeout (when `TIMEOUT_CYCLES`>0):
  - The counter clears on every state entry and increments each cycle spent in REQ or RSP.
  - When the counter reaches `TIMEOUT_CYCLES` and no gnt (REQ) or rvalid (RSP) arrives in that cycle, the unit returns to IDLE, pulses `timeout_o` and drops `data_req_o`.
  - A gnt or rvalid in the same cycle as expiry wins; no timeout is signalled.
- Reset:
  - All outputs go to 0, the state goes to IDLE and the counter clears.
  - Reset during REQ or RSP abandons the transaction silently, with no pulse.
  - gnt or rvalid arriving after reset is ignored in IDLE.
- At most one of `done_o`, `misalign_o`, `timeout_o` is high in any cycle.

## Timing
- Cycle 0: `req_i` accepted in IDLE.
- Cycle 1: state REQ, `data_req_o`=1, bus outputs valid.
- Grant in cycle N puts the unit in RSP at N+1.
- Response in cycle M gives `done_o`=1, `busy_o`=0, state IDLE at M+1. A new `req_i` is accepted in M+1.
- Minimum store latency: 3 cycles from acceptance to `done_o` (gnt in cycle 1, rvalid in cycle 2).
- Misaligned request: `misalign_o` in cycle 1, `busy_o` stays 0, and a new request can be accepted in cycle 1.
- Outputs are registered, with no combinational path from `data_gnt_i` or `data_rvalid_i` to any output.

## Test plan
- Byte store: addr 0x1003, wdata 0x000000A5. Required: `data_addr_o`=0x1000, be=1000, wdata=0xA5A5A5A5. With gnt in cycle 1 and rvalid in cycle 2, `done_o` pulses in cycle 3.
- Halfword and word stores: addr 0x2002 half 0x1234 gives be=1100, wdata=0x12341234. Addr 0x2004 word 0xDEADBEEF gives be=1111. Grant delayed 3 cycles: outputs held stable and `data_req_o` stays high until gnt.
- Misalignment: half at 0x2001, word at 0x2006, and size 11 each pulse `misalign_o` one cycle later, with `data_req_o` never asserted and `busy_o` staying 0.
- Timeout with `TIMEOUT_CYCLES`=4: no grant gives `timeout_o` after 4 REQ cycles and the unit returns to IDLE. Grant arriving on the expiry cycle gives no timeout and the transaction proceeds to RSP.
- Back-to-back: the second `req_i` is held during the first transaction, is ignored while busy, and is accepted in the `done_o` cycle. `req_i` toggled mid-transaction has no effect.
- Reset in RSP: all outputs 0 and IDLE; a subsequent stray rvalid produces no `done_o`.

Source files
------------

// File: rtl/miriscv_store_unit.sv
// -----------------------------------------------------------------------------
// miriscv_store_unit
//
// Store-side data memory adapter. Accepts one store at a time from the execute
// stage, checks alignment, formats byte enables and lane-replicated write data,
// then runs the request/grant/response handshake on the data memory port.
// Completion, rejection and bus timeout are reported as one-cycle pulses.
//
// Parameters
//   TIMEOUT_CYCLES : max cycles spent in REQ or RSP before abort (0 = never)
//   CNT_WIDTH      : timeout counter width, TIMEOUT_CYCLES < 2**CNT_WIDTH
//
// Ports
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_i               : store request (sampled only while idle)
//   size_i              : 00 byte, 01 half, 10 word, 11 reserved
//   addr_i, wdata_i     : byte address, right-aligned store data
//   busy_o              : transaction in progress
//   done_o              : pulse, store completed
//   misalign_o          : pulse, request rejected
//   timeout_o           : pulse, transaction aborted
//   data_req_o/we_o     : memory request / write enable
//   data_be_o           : byte enables
//   data_addr_o         : word-aligned address
//   data_wdata_o        : lane-replicated write data
//   data_gnt_i          : grant for the pending request
//   data_rvalid_i       : write response
// -----------------------------------------------------------------------------
module miriscv_store_unit #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        timeout_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RSP  = 2'b10
    } state_t;

    state_t               state_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    logic        bad_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        expiry_s;

    // Lane formatting and alignment check of the incoming request.
    always_comb begin
        bad_s   = 1'b0;
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (size_i)
            2'b00: begin
                be_s    = 4'b0001 << addr_i[1:0];
                wdata_s = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                bad_s   = addr_i[0];
                be_s    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{wdata_i[15:0]}};
            end
            2'b10: begin
                bad_s   = (addr_i[1:0] != 2'b00);
                be_s    = 4'b1111;
                wdata_s = wdata_i;
            end
            default: begin
                bad_s   = 1'b1;
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Expiry fires in the cycle where the counter would reach TIMEOUT_CYCLES,
    // so a timed-out request is held on the bus for exactly TIMEOUT_CYCLES.
    always_comb begin
        if (TIMEOUT_CYCLES != 0) begin
            expiry_s = (cnt_r == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
        end else begin
            expiry_s = 1'b0;
        end
    end

    // Handshake FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            misalign_o   <= 1'b0;
            timeout_o    <= 1'b0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= 32'h0000_0000;
            data_wdata_o <= 32'h0000_0000;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_i) begin
                        if (bad_s) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state_r      <= ST_REQ;
                            cnt_r        <= '0;
                            busy_o       <= 1'b1;
                            data_req_o   <= 1'b1;
                            data_we_o    <= 1'b1;
                            data_be_o    <= be_s;
                            data_addr_o  <= {addr_i[31:2], 2'b00};
                            data_wdata_o <= wdata_s;
                        end
                    end
                end
                ST_REQ: begin
                    // Grant wins over a simultaneous expiry.
                    if (data_gnt_i) begin
                        state_r    <= ST_RSP;
                        cnt_r      <= '0;
                        data_req_o <= 1'b0;
                        data_we_o  <= 1'b0;
                    end else if (expiry_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= '0;
                        busy_o     <= 1'b0;
                        timeout_o  <= 1'b1;
                        data_req_o <= 1'b0;
                        data_we_o  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                ST_RSP: begin
                    if (data_rvalid_i) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else if (expiry_s) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= '0;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    busy_o     <= 1'b0;
                    data_req_o <= 1'b0;
                    data_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_store_unit.sv
// -----------------------------------------------------------------------------
// tb_miriscv_store_unit
//
// Scoreboard bench for miriscv_store_unit (TIMEOUT_CYCLES = 4). Each driven
// store pushes its expected bus beat and its expected completion event; a
// negedge monitor pops and compares them when the DUT presents a new request
// or pulses done/misalign/timeout. Directed checks cover cycle timing.
// -----------------------------------------------------------------------------
module tb_miriscv_store_unit;

    localparam logic [2:0] EV_DONE = 3'b100;
    localparam logic [2:0] EV_MIS  = 3'b010;
    localparam logic [2:0] EV_TO   = 3'b001;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o, done_o, misalign_o, timeout_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    logic req_prev = 1'b0;
    bus_t cur_bus;

    bus_t       q_bus[$];
    logic [2:0] q_evt[$];

    miriscv_store_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .size_i(size_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .misalign_o(misalign_o), .timeout_o(timeout_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i)
    );

    // Free-running clock, 10 ns period.
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference formatting: walk the byte lanes covered by the access.
    task automatic model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         output bus_t b, output bit bad);
        int nb;
        int off;
        nb  = (sz == 2'b11) ? 1 : (1 << sz);
        off = int'(a[1:0]);
        bad = (sz == 2'b11) || ((off % nb) != 0);
        b.addr = a & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            b.be[i]          = (i >= off) && (i < off + nb);
            b.wdata[8*i +: 8] = d[8*(i % nb) +: 8];
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request and register what it should produce.
    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] ev);
        bus_t b;
        bit   bad;
        model(sz, a, d, b, bad);
        req_i   = 1'b1;
        size_i  = sz;
        addr_i  = a;
        wdata_i = d;
        if (!bad) q_bus.push_back(b);
        if (ev != 3'b000) q_evt.push_back(ev);
    endtask

    // Full store with given grant / response delays; misaligned ones just reject.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input int gd, input int rd);
        bus_t b;
        bit   bad;
        model(sz, a, d, b, bad);
        issue(sz, a, d, bad ? EV_MIS : EV_DONE);
        cyc();
        req_i = 1'b0;
        if (bad) begin
            check_eq("mis_busy", busy_o, 0);
            check_eq("mis_req", data_req_o, 0);
        end else begin
            check_eq("acc_busy", busy_o, 1);
            repeat (gd) cyc();
            data_gnt_i = 1'b1;
            cyc();
            data_gnt_i = 1'b0;
            repeat (rd) cyc();
            data_rvalid_i = 1'b1;
            cyc();
            data_rvalid_i = 1'b0;
            check_eq("cpl_done", done_o, 1);
            check_eq("cpl_busy", busy_o, 0);
        end
    endtask

    // Scoreboard monitor: pops expectations when the DUT produces output.
    always @(negedge clk_i) begin
        logic [2:0] evt;
        if (mon_en) begin
            evt = {done_o, misalign_o, timeout_o};
            if (evt != 3'b000) begin
                if (q_evt.size() == 0) check_eq("unexp_evt", 32'(evt), 0);
                else check_eq("evt", 32'(evt), 32'(q_evt.pop_front()));
            end
            if (data_req_o && !req_prev) begin
                if (q_bus.size() == 0) begin
                    check_eq("unexp_req", 1, 0);
                end else begin
                    cur_bus = q_bus.pop_front();
                    check_eq("bus_addr", data_addr_o, cur_bus.addr);
                    check_eq("bus_be", 32'(data_be_o), 32'(cur_bus.be));
                    check_eq("bus_wdata", data_wdata_o, cur_bus.wdata);
                    check_eq("bus_we", data_we_o, 1);
                end
            end else if (data_req_o) begin
                check_eq("hold_addr", data_addr_o, cur_bus.addr);
                check_eq("hold_be", 32'(data_be_o), 32'(cur_bus.be));
                check_eq("hold_wdata", data_wdata_o, cur_bus.wdata);
            end
            req_prev = data_req_o;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; req_i = 1'b0; size_i = 2'b00; addr_i = 32'h0; wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        cyc(); cyc();
        // Reset state
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_req", data_req_o, 0);
        check_eq("rst_pulses", {29'd0, done_o, misalign_o, timeout_o}, 0);
        check_eq("rst_addr", data_addr_o, 0);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        cyc();

        // Byte store with exact cycle timing
        issue(2'b00, 32'h0000_1003, 32'h0000_00A5, EV_DONE);
        cyc();                                    // cycle 1
        req_i = 1'b0;
        check_eq("b_req", data_req_o, 1);
        check_eq("b_addr", data_addr_o, 32'h0000_1000);
        check_eq("b_be", 32'(data_be_o), 32'h8);
        check_eq("b_wdata", data_wdata_o, 32'hA5A5_A5A5);
        data_gnt_i = 1'b1;
        cyc();                                    // cycle 2
        data_gnt_i = 1'b0;
        check_eq("b_rsp_req", data_req_o, 0);
        check_eq("b_rsp_done", done_o, 0);
        data_rvalid_i = 1'b1;
        cyc();                                    // cycle 3
        data_rvalid_i = 1'b0;
        check_eq("b_done", done_o, 1);
        check_eq("b_busy", busy_o, 0);
        cyc();
        check_eq("b_done_pulse", done_o, 0);

        // Halfword and word; word grant delayed 3 cycles
        issue(2'b01, 32'h0000_2002, 32'h0000_1234, EV_DONE);
        cyc();
        req_i = 1'b0;
        check_eq("h_be", 32'(data_be_o), 32'hC);
        check_eq("h_wdata", data_wdata_o, 32'h1234_1234);
        data_gnt_i = 1'b1; cyc(); data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; cyc(); data_rvalid_i = 1'b0;
        run_store(2'b10, 32'h0000_2004, 32'hDEAD_BEEF, 3, 1);
        check_eq("w_be_last", 32'(data_be_o), 32'hF);

        // Misaligned / reserved requests
        run_store(2'b01, 32'h0000_2001, 32'h0000_5555, 0, 0);
        run_store(2'b10, 32'h0000_2006, 32'h1111_2222, 0, 0);
        run_store(2'b11, 32'h0000_2000, 32'h3333_4444, 0, 0);
        cyc();

        // Timeout: no grant, request held for 4 cycles
        issue(2'b10, 32'h0000_3000, 32'hCAFE_F00D, EV_TO);
        cyc();                                    // cycle 1
        req_i = 1'b0;
        repeat (3) cyc();                         // cycle 4
        check_eq("to_req_c4", data_req_o, 1);
        check_eq("to_pulse_c4", timeout_o, 0);
        cyc();                                    // cycle 5
        check_eq("to_pulse", timeout_o, 1);
        check_eq("to_req", data_req_o, 0);
        check_eq("to_busy", busy_o, 0);
        cyc();

        // Grant on the expiry cycle wins
        issue(2'b00, 32'h0000_3001, 32'h0000_0077, EV_DONE);
        cyc();
        req_i = 1'b0;
        repeat (3) cyc();
        data_gnt_i = 1'b1;
        cyc();
        data_gnt_i = 1'b0;
        check_eq("exp_gnt_to", timeout_o, 0);
        check_eq("exp_gnt_busy", busy_o, 1);
        check_eq("exp_gnt_req", data_req_o, 0);
        data_rvalid_i = 1'b1; cyc(); data_rvalid_i = 1'b0;
        check_eq("exp_gnt_done", done_o, 1);

        // Back-to-back: second request held, accepted in the done cycle
        issue(2'b10, 32'h0000_4000, 32'h0102_0304, EV_DONE);
        cyc();
        issue(2'b01, 32'h0000_4006, 32'h0000_ABCD, EV_DONE);
        cyc();
        check_eq("b2b_ignored_busy", busy_o, 1);
        data_gnt_i = 1'b1; cyc(); data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; cyc(); data_rvalid_i = 1'b0;
        check_eq("b2b_done", done_o, 1);
        cyc();
        check_eq("b2b_second_req", data_req_o, 1);
        req_i = 1'b0; cyc();
        req_i = 1'b1; size_i = 2'b00; addr_i = 32'h0000_9999; cyc();
        req_i = 1'b0; cyc();
        data_gnt_i = 1'b1; cyc(); data_gnt_i = 1'b0;
        req_i = 1'b1; cyc(); req_i = 1'b0;
        data_rvalid_i = 1'b1; cyc(); data_rvalid_i = 1'b0;
        check_eq("b2b_done2", done_o, 1);
        cyc();

        // Reset during RSP, then stray rvalid and gnt
        issue(2'b10, 32'h0000_5000, 32'h5A5A_5A5A, 3'b000);
        cyc();
        req_i = 1'b0;
        data_gnt_i = 1'b1; cyc(); data_gnt_i = 1'b0;
        rst_i = 1'b1; cyc(); rst_i = 1'b0;
        check_eq("rr_busy", busy_o, 0);
        check_eq("rr_req", data_req_o, 0);
        check_eq("rr_we", data_we_o, 0);
        check_eq("rr_be", 32'(data_be_o), 0);
        check_eq("rr_wdata", data_wdata_o, 0);
        data_rvalid_i = 1'b1; data_gnt_i = 1'b1; cyc();
        data_rvalid_i = 1'b0; data_gnt_i = 1'b0; cyc();
        check_eq("rr_stray_done", done_o, 0);
        check_eq("rr_stray_busy", busy_o, 0);

        // A few random stores
        for (int k = 0; k < 8; k++) begin
            run_store(2'($urandom_range(0, 3)), $urandom, $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 2));
            cyc();
        end

        repeat (2) cyc();
        check_eq("q_bus_left", q_bus.size(), 0);
        check_eq("q_evt_left", q_evt.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
